bw_mul_q88: RTL and testbench
=============================

Name: bw_mul_q88

Overview:
- Signed two's-complement fixed-point multiplier for Q8.8 operands. The product is also Q8.8.
- Core is a Baugh-Wooley partial-product array, with one output register stage.
- Used by the linear-regression datapath for two jobs: feature×weight products when forming y_cap, and error×feature products when forming weight updates.
- The datapath instantiates eight of these in parallel.

Parameters:
- WIDTH, 16: operand and result width in bits (two's complement).
- FRAC, 8: number of fractional bits in operands and result.

Ports:
- CLK, input, 1: clock; rising-edge active.
- RST, input, 1: asynchronous reset, active-high.
- in_valid, input, 1: a and b are valid this cycle.
- a, input, WIDTH: signed multiplicand, Q8.8.
- b, input, WIDTH: signed multiplier, Q8.8.
- out_valid, output, 1: p holds the result of the operands accepted one cycle earlier.
- p, output, WIDTH: signed product, Q8.8.

Behaviour:
- Reset: while RST=1, asynchronously force p=0 and out_valid=0. Hold them there until the first rising CLK edge after RST falls.
- Reset mid-operation: any in-flight product is discarded. out_valid is low on the first cycle after release.
- Arithmetic:
  - full = a*b, signed, 2*WIDTH bits, Q16.16. Form it with a Baugh-Wooley array: invert the sign-row/sign-column partial-product bits, and add correction ones at bit positions WIDTH and 2*WIDTH-1.
  - Result = full[WIDTH+FRAC-1 : FRAC], i.e. full[23:8].
- Rounding: truncation, equivalent to an arithmetic shift right by FRAC. This rounds toward −∞, so tiny negative products give −1 LSB (0xFFFF), not 0.
- Overflow: no saturation. Bits above bit 23 are discarded, so an out-of-range result wraps modulo 2^16.
- Latency and throughput:
  - Exactly 1 cycle: operands sampled at edge k appear on p after edge k.
  - Fully pipelined: accepts new operands every cycle.
- out_valid: registered copy of in_valid.
- p update rule: p is written only when in_valid=1. When in_valid=0, p holds its last value and out_valid drops to 0.
- No back-pressure: there is no ready signal, and the consumer must accept the result every cycle.
- Operand symmetry: swapping a and b gives an identical p.
- The −32768 raw value (0x8000, i.e. −128.0) is a legal operand and gets no special handling.

Decomposition:
- Shared package (e.g. fxp_pkg):
  - WIDTH=16 and FRAC=8 constants.
  - A q88_t typedef (signed [15:0]).
  - The Q8.8 literal helpers used by the regression datapath (e.g. ONE=16'h0100).
- One natural sub-module, bw_pp_array: purely combinational.
  - Generates the WIDTH×WIDTH Baugh-Wooley partial products and reduces them (row-ripple or carry-save, plus a final adder) to the 2*WIDTH-bit product.
- bw_mul_q88 wraps bw_pp_array with the bit slice, the output register and the valid register.

Test Plan:
- Reset, then in_valid=1, a=0x0200 (2.0), b=0x0040 (0.25) → next cycle p=0x0080 (0.5), out_valid=1. Assert RST asynchronously mid-cycle → p=0 and out_valid=0 immediately.
- Sign handling:
  - a=0xFF00 (−1.0), b=0x0040 → p=0xFFC0 (−0.25).
  - a=0xFF00, b=0xFF00 → p=0x0100 (+1.0).
- Truncation:
  - a=0x0001, b=0x0001 → p=0x0000.
  - a=0xFFFF, b=0x0001 → p=0xFFFF (floor of −2^-16).
  - a=0x0180 (1.5), b=0x0180 → p=0x0240 (2.25).
- Wrap, no saturation:
  - a=0x7FFF, b=0x7FFF → p=0xFF00.
  - a=0x8000, b=0x8000 → p=0x0000.
  - a=0x1000 (16.0), b=0x1000 → p=0x0000.
- Back-to-back and hold:
  - Drive a 4-cycle stream (2×0.25, 4×0.25, 3×0.25, 6×0.25) → p=0x0080, 0x0100, 0x00C0, 0x0180 on consecutive cycles.
  - Then drop in_valid → p holds 0x0180 and out_valid=0.
- Randomized: 10k random a/b pairs, including 0x8000 and 0x7FFF corners. Require p == (($signed(a)*$signed(b))>>>8)[15:0] one cycle later, and p(a,b) == p(b,a).

Source files
------------

// File: rtl/fxp_pkg.sv
// ============================================================================
// Module      : fxp_pkg
// Description : Shared Q8.8 fixed-point constants, types and literal helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fxp_pkg;

    localparam int Q88_WIDTH = 16;
    localparam int Q88_FRAC  = 8;

    typedef logic signed [Q88_WIDTH-1:0] q88_t;

    localparam q88_t Q88_ZERO    = 16'sh0000;
    localparam q88_t Q88_ONE     = 16'sh0100;
    localparam q88_t Q88_HALF    = 16'sh0080;
    localparam q88_t Q88_QUARTER = 16'sh0040;
    localparam q88_t Q88_MAX     = 16'sh7FFF;
    localparam q88_t Q88_MIN     = 16'sh8000;

    // Integer part only; the caller keeps the value within -128..127.
    function automatic q88_t q88_from_int(input logic signed [7:0] i_val);
        return {i_val, 8'h00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/bw_pp_array.sv
// ============================================================================
// Module      : bw_pp_array
// Description : Combinational Baugh-Wooley signed multiplier, WIDTH x WIDTH.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bw_pp_array
    import fxp_pkg::*;
#(
    parameter int WIDTH = Q88_WIDTH
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] o_full
);

    localparam logic [2*WIDTH-1:0] c_CORRECTION =
        (2*WIDTH)'(1) << WIDTH | (2*WIDTH)'(1) << (2*WIDTH-1);

    logic [WIDTH-1:0]   w_pp   [WIDTH];
    logic [2*WIDTH-1:0] w_rows [WIDTH];

    // Terms mixing exactly one sign bit carry negative weight, hence inverted.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_row
        for (genvar gj = 0; gj < WIDTH; gj++) begin : g_col
            if ((gi == WIDTH-1) != (gj == WIDTH-1)) begin : g_inv
                assign w_pp[gi][gj] = ~(a[gj] & b[gi]);
            end else begin : g_pos
                assign w_pp[gi][gj] = a[gj] & b[gi];
            end
        end
        assign w_rows[gi] = {{WIDTH{1'b0}}, w_pp[gi]} << gi;
    end

    always_comb begin
        o_full = c_CORRECTION;
        for (int i = 0; i < WIDTH; i++) begin
            o_full = o_full + w_rows[i];
        end
    end

endmodule

`default_nettype wire

// File: rtl/bw_mul_q88.sv
// ============================================================================
// Module      : bw_mul_q88
// Description : Pipelined Q8.8 signed multiplier, truncating, wrapping, 1 cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bw_mul_q88
    import fxp_pkg::*;
#(
    parameter int WIDTH = Q88_WIDTH,
    parameter int FRAC  = Q88_FRAC
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] p
);

    logic [2*WIDTH-1:0] w_full;
    logic [WIDTH-1:0]   w_slice;
    logic               w_unused_bits;
    logic [WIDTH-1:0]   r_p;
    logic               r_valid;

    bw_pp_array #(
        .WIDTH (WIDTH)
    ) u_pp_array (
        .a      (a),
        .b      (b),
        .o_full (w_full)
    );

    // Dropping the low bits floors toward -inf; dropping the high bits wraps.
    assign w_slice       = w_full[WIDTH+FRAC-1:FRAC];
    assign w_unused_bits = ^{w_full[2*WIDTH-1:WIDTH+FRAC], w_full[FRAC-1:0]};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_p     <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_p <= w_slice;
            end
        end
    end

    assign p         = r_p;
    assign out_valid = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_bw_mul_q88.sv
// ============================================================================
// Module      : tb_bw_mul_q88
// Description : Scoreboard bench for bw_mul_q88 with directed and random vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bw_mul_q88;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        out_valid;
    logic [15:0] p;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];

    bw_mul_q88 dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .p         (p)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, expv);
        end
    endtask

    task automatic drive(input logic [15:0] ia, input logic [15:0] ib, input logic [15:0] expv);
        @(negedge CLK);
        in_valid = 1'b1;
        a        = ia;
        b        = ib;
        exp_q.push_back(expv);
    endtask

    task automatic idle();
        @(negedge CLK);
        in_valid = 1'b0;
    endtask

    // Monitor: each valid result is matched against the oldest expectation.
    always @(negedge CLK) begin
        if (!RST && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", 16'h0001, 16'h0000);
            end else begin
                chk("product", p, exp_q.pop_front());
            end
        end
    end

    initial begin
        logic signed [31:0] f;
        logic [15:0]        ra;
        logic [15:0]        rb;
        int                 sel;

        // Reset state
        #2;
        chk("reset_p", p, 16'h0000);
        chk("reset_valid", {15'd0, out_valid}, 16'h0000);
        @(negedge CLK);
        RST = 1'b0;

        // Basic product, then asynchronous reset mid-cycle
        drive(16'h0200, 16'h0040, 16'h0080);
        @(posedge CLK);
        #2;
        chk("pre_reset_p", p, 16'h0080);
        chk("pre_reset_valid", {15'd0, out_valid}, 16'h0001);
        RST = 1'b1;
        #1;
        chk("async_reset_p", p, 16'h0000);
        chk("async_reset_valid", {15'd0, out_valid}, 16'h0000);
        exp_q.delete();
        in_valid = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("release_valid", {15'd0, out_valid}, 16'h0000);

        // Sign handling, truncation and wrap
        drive(16'hFF00, 16'h0040, 16'hFFC0);
        drive(16'hFF00, 16'hFF00, 16'h0100);
        drive(16'h0001, 16'h0001, 16'h0000);
        drive(16'hFFFF, 16'h0001, 16'hFFFF);
        drive(16'h0001, 16'hFFFF, 16'hFFFF);
        drive(16'h0180, 16'h0180, 16'h0240);
        drive(16'h7FFF, 16'h7FFF, 16'hFF00);
        drive(16'h8000, 16'h8000, 16'h0000);
        drive(16'h1000, 16'h1000, 16'h0000);
        drive(16'h8000, 16'h7FFF, 16'h0080);
        drive(16'h8000, 16'h0100, 16'h8000);

        // Back-to-back stream, then hold
        drive(16'h0200, 16'h0040, 16'h0080);
        drive(16'h0400, 16'h0040, 16'h0100);
        drive(16'h0300, 16'h0040, 16'h00C0);
        drive(16'h0600, 16'h0040, 16'h0180);
        idle();
        idle();
        chk("hold_p", p, 16'h0180);
        chk("hold_valid", {15'd0, out_valid}, 16'h0000);
        drive(16'hFFFF, 16'hFFFF, 16'h0000);
        idle();
        idle();
        chk("hold_p2", p, 16'h0000);

        // Random pairs, each issued both ways round
        for (int i = 0; i < 5000; i++) begin
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            sel = int'($urandom_range(0, 15));
            if (sel == 0) ra = 16'h8000;
            if (sel == 1) ra = 16'h7FFF;
            if (sel == 2) rb = 16'h8000;
            if (sel == 3) rb = 16'h7FFF;
            f = $signed(ra) * $signed(rb);
            drive(ra, rb, f[23:8]);
            drive(rb, ra, f[23:8]);
        end

        repeat (4) idle();
        chk("scoreboard_drained", 16'(exp_q.size()), 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
